// File: rtl/sass_pkg.sv
// Shared definitions for the PWM audio transmit/receive pair.
package sass_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } dec_state_t;

    localparam int PWM_PERIOD = 512;
    localparam int PWM_TOL    = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus previous-value flop; reports the synchronized
// level and single-cycle rise/fall pulses for an asynchronous input.
module sync_edge_det (
    input  logic hwclk,
    input  logic n_rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    always_ff @(posedge hwclk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign level = sync2_reg;
    assign rise  = sync2_reg & ~prev_reg;
    assign fall  = ~sync2_reg & prev_reg;

endmodule

// File: rtl/pwm_sample_decoder.sv
// Recovers PWM-encoded samples: measures the high time of each frame and
// flags frames whose length falls outside PERIOD +/- TOL.
module pwm_sample_decoder
    import sass_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int PERIOD = PWM_PERIOD,
    parameter int TOL    = PWM_TOL
) (
    input  logic             hwclk,
    input  logic             n_rst,
    input  logic             en,
    input  logic             pwm_i,
    output logic [WIDTH-1:0] sample,
    output logic             sample_valid,
    output logic             period_err,
    output logic             locked
);

    localparam int CW = $clog2(PERIOD + TOL) + 1;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t CNT_MAX = '1;
    localparam cnt_t CNT_ONE = cnt_t'(1);
    localparam cnt_t P_NOM   = cnt_t'(PERIOD);
    localparam cnt_t P_MIN   = cnt_t'(PERIOD - TOL);
    localparam cnt_t P_MAX   = cnt_t'(PERIOD + TOL);
    localparam logic [WIDTH-1:0] FULL = '1;
    localparam cnt_t FULL_CNT = cnt_t'(FULL);

    logic level;
    logic rise;
    logic fall;

    dec_state_t state_reg;
    cnt_t       hcnt_reg;
    cnt_t       pcnt_reg;
    logic [1:0] good_reg;

    cnt_t       hcnt_inc;
    cnt_t       pcnt_inc;
    logic [1:0] good_inc;
    logic [WIDTH-1:0] hcnt_clamped;

    sync_edge_det u_sync (
        .hwclk (hwclk),
        .n_rst (n_rst),
        .din   (pwm_i),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    assign hcnt_inc     = (hcnt_reg == CNT_MAX) ? hcnt_reg : hcnt_reg + CNT_ONE;
    assign pcnt_inc     = (pcnt_reg == CNT_MAX) ? pcnt_reg : pcnt_reg + CNT_ONE;
    assign good_inc     = (good_reg == 2'd3) ? good_reg : good_reg + 2'd1;
    assign hcnt_clamped = (hcnt_reg > FULL_CNT) ? FULL : hcnt_reg[WIDTH-1:0];

    // The edge that ends a frame also opens the next one, so every branch
    // taken on rise reloads both counters to 1.
    always_ff @(posedge hwclk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg    <= IDLE;
            hcnt_reg     <= '0;
            pcnt_reg     <= '0;
            good_reg     <= 2'd0;
            sample       <= '0;
            sample_valid <= 1'b0;
            period_err   <= 1'b0;
            locked       <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            period_err   <= 1'b0;
            if (!en) begin
                state_reg <= IDLE;
                hcnt_reg  <= '0;
                pcnt_reg  <= '0;
                good_reg  <= 2'd0;
                locked    <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (rise) begin
                            state_reg <= HIGH;
                            hcnt_reg  <= CNT_ONE;
                            pcnt_reg  <= CNT_ONE;
                        end else if (pcnt_reg >= P_NOM) begin
                            sample       <= level ? FULL : '0;
                            sample_valid <= 1'b1;
                            pcnt_reg     <= CNT_ONE;
                        end else begin
                            pcnt_reg <= pcnt_inc;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            state_reg <= LOW;
                            pcnt_reg  <= pcnt_inc;
                        end else if (pcnt_reg >= P_MAX) begin
                            sample       <= FULL;
                            sample_valid <= 1'b1;
                            state_reg    <= IDLE;
                            hcnt_reg     <= '0;
                            pcnt_reg     <= CNT_ONE;
                        end else begin
                            hcnt_reg <= hcnt_inc;
                            pcnt_reg <= pcnt_inc;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            if (pcnt_reg >= P_MIN && pcnt_reg <= P_MAX) begin
                                sample       <= hcnt_clamped;
                                sample_valid <= 1'b1;
                                good_reg     <= good_inc;
                                if (good_inc >= 2'd2) begin
                                    locked <= 1'b1;
                                end
                            end else begin
                                period_err <= 1'b1;
                                good_reg   <= 2'd0;
                                locked     <= 1'b0;
                            end
                            state_reg <= HIGH;
                            hcnt_reg  <= CNT_ONE;
                            pcnt_reg  <= CNT_ONE;
                        end else if (pcnt_reg >= P_MAX) begin
                            period_err <= 1'b1;
                            good_reg   <= 2'd0;
                            locked     <= 1'b0;
                            state_reg  <= IDLE;
                            hcnt_reg   <= '0;
                            pcnt_reg   <= CNT_ONE;
                        end else begin
                            pcnt_reg <= pcnt_inc;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
